bmem_responder: RTL and testbench

BMEM_RESPONDER -- requirements
Module: bmem_responder

---
 rtl/bmem_pkg.sv | 21 ++
 rtl/bmem_store.sv | 35 +++
 rtl/bmem_responder.sv | 164 ++++++++++++++++
 tb/tb_bmem_responder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/bmem_pkg.sv
// Shared types and constants for the burst memory responder.
// Holds the FSM state type, the beat width, and the helper that derives
// the burst length from the line size.
package bmem_pkg;

  localparam int unsigned BEAT_WIDTH = 64;

  typedef enum logic [2:0] {
    StIdle,
    StRdWait,
    StRdBurst,
    StWrBeats,
    StWrResp
  } state_e;

  // A line of 2**log2_wordsize bits is carried as 64-bit beats.
  function automatic int unsigned burst_len(input int unsigned log2_wordsize);
    return 32'd1 << (log2_wordsize - 6);
  endfunction

endpackage

// File: rtl/bmem_store.sv
// Backing store for the responder: 2**LOG2_DEPTH lines of 2**LOG2_WORDSIZE bits.
// Ports:
//   clk_i    clock
//   we_i     full-line write enable
//   waddr_i  write line index
//   wdata_i  write line data
//   raddr_i  read line index
//   rdata_o  read line data (combinational read)
// Contents have no reset and survive responder resets.
module bmem_store #(
  parameter int unsigned LOG2_WORDSIZE = 8,
  parameter int unsigned LOG2_DEPTH    = 8
) (
  input  logic                            clk_i,
  input  logic                            we_i,
  input  logic [LOG2_DEPTH-1:0]           waddr_i,
  input  logic [(1 << LOG2_WORDSIZE)-1:0] wdata_i,
  input  logic [LOG2_DEPTH-1:0]           raddr_i,
  output logic [(1 << LOG2_WORDSIZE)-1:0] rdata_o
);

  localparam int unsigned LineW = 1 << LOG2_WORDSIZE;
  localparam int unsigned Depth = 1 << LOG2_DEPTH;

  logic [LineW-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bmem_responder.sv
// Burst memory responder: serves line reads and writes as bursts of 64-bit beats.
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   bmem_address  byte address, sampled at request acceptance
//   bmem_read     read request pulse
//   bmem_write    write request pulse (qualifies beat 0)
//   bmem_wdata    write beat data
//   bmem_rdata    read beat data, zero when no read beat is presented
//   bmem_resp     read beat valid / write completion
//   bmem_error    sticky protocol-error flag
// Optional feature: define BMEM_RESPONDER_ERRCHK_EN to latch protocol errors on
// bmem_error; otherwise bmem_error is tied low. Bad requests are ignored either way.
module bmem_responder
  import bmem_pkg::*;
#(
  parameter int unsigned LOG2_WORDSIZE = 8,
  parameter int unsigned LOG2_DEPTH    = 8,
  parameter int unsigned READ_LATENCY  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bmem_address,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic [63:0] bmem_rdata,
  output logic        bmem_resp,
  output logic        bmem_error
);

  localparam int unsigned LineW    = 1 << LOG2_WORDSIZE;
  localparam int unsigned BeatCntW = LOG2_WORDSIZE - 6;
  localparam logic [3:0]  LatLast  = 4'(READ_LATENCY - 1);

  state_e                state_q, state_d;
  logic [BeatCntW-1:0]   beat_q, beat_d;
  logic [3:0]            lat_q, lat_d;
  logic [LOG2_DEPTH-1:0] idx_q, idx_d;
  logic [LineW-1:0]      wbuf_q, wbuf_d;
  logic [LineW-1:0]      wline;
  logic [LineW-1:0]      rline;
  logic [LOG2_DEPTH-1:0] addr_idx;
  logic                  store_we;
  logic                  bad_req;

  assign addr_idx = bmem_address[LOG2_WORDSIZE-3 +: LOG2_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      beat_q  <= '0;
      lat_q   <= '0;
      idx_q   <= '0;
      wbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      idx_q   <= idx_d;
      wbuf_q  <= wbuf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    lat_d    = lat_q;
    idx_d    = idx_q;
    wbuf_d   = wbuf_q;
    store_we = 1'b0;
    bad_req  = 1'b0;
    // Line buffer with the incoming beat merged in; beat_q is 0 in idle, so this
    // also places beat 0 at acceptance.
    wline = wbuf_q;
    wline[beat_q*BEAT_WIDTH +: BEAT_WIDTH] = bmem_wdata;

    unique case (state_q)
      StIdle: begin
        if (bmem_read && bmem_write) begin
          bad_req = 1'b1;
        end else if (bmem_read) begin
          idx_d   = addr_idx;
          lat_d   = '0;
          state_d = (READ_LATENCY == 1) ? StRdBurst : StRdWait;
        end else if (bmem_write) begin
          idx_d   = addr_idx;
          wbuf_d  = wline;
          beat_d  = beat_q + 1'b1;
          state_d = StWrBeats;
        end
      end
      StRdWait: begin
        bad_req = bmem_read | bmem_write;
        if (lat_q == LatLast) begin
          lat_d   = '0;
          state_d = StRdBurst;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      StRdBurst: begin
        bad_req = bmem_read | bmem_write;
        beat_d  = beat_q + 1'b1;
        if (&beat_q) begin
          state_d = StIdle;
        end
      end
      StWrBeats: begin
        bad_req = bmem_read | bmem_write;
        wbuf_d  = wline;
        beat_d  = beat_q + 1'b1;
        if (&beat_q) begin
          // Whole line lands in the store on the edge that enters WR_RESP.
          store_we = 1'b1;
          state_d  = StWrResp;
        end
      end
      StWrResp: begin
        bad_req = bmem_read | bmem_write;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  bmem_store #(
    .LOG2_WORDSIZE(LOG2_WORDSIZE),
    .LOG2_DEPTH   (LOG2_DEPTH)
  ) u_store (
    .clk_i  (clk),
    .we_i   (store_we),
    .waddr_i(idx_q),
    .wdata_i(wline),
    .raddr_i(idx_q),
    .rdata_o(rline)
  );

  assign bmem_resp  = (state_q == StRdBurst) || (state_q == StWrResp);
  assign bmem_rdata = (state_q == StRdBurst) ? rline[beat_q*BEAT_WIDTH +: BEAT_WIDTH] : '0;

`ifdef BMEM_RESPONDER_ERRCHK_EN
  logic error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else if (bad_req) begin
      error_q <= 1'b1;
    end
  end

  assign bmem_error = error_q;
`else
  logic unused_bad_req;
  assign unused_bad_req = bad_req;
  assign bmem_error     = 1'b0;
`endif

  // Only the line-index bits of the address matter.
  logic unused_addr;
  assign unused_addr = ^bmem_address;

endmodule

// File: tb/tb_bmem_responder.sv
// Directed self-checking bench for bmem_responder with default parameters
// (256-bit lines, 4 beats, read latency 4, 256 lines).
module tb_bmem_responder;

`ifdef BMEM_RESPONDER_ERRCHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] bmem_address;
  logic        bmem_read;
  logic        bmem_write;
  logic [63:0] bmem_wdata;
  logic [63:0] bmem_rdata;
  logic        bmem_resp;
  logic        bmem_error;

  int tests_run = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  bmem_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bmem_address(bmem_address),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_rdata  (bmem_rdata),
    .bmem_resp   (bmem_resp),
    .bmem_error  (bmem_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Full 4-beat write; checks resp timing and that rdata stays 0.
  task automatic do_write(input logic [31:0] addr, input logic [63:0] b0, input logic [63:0] b1,
                          input logic [63:0] b2, input logic [63:0] b3, input string tag);
    logic [63:0] b[4];
    b = '{b0, b1, b2, b3};
    bmem_address = addr;
    bmem_write   = 1'b1;
    bmem_wdata   = b[0];
    tick();
    bmem_write = 1'b0;
    chk({tag, " wr resp beat0"}, 64'(bmem_resp), 64'd0);
    for (int i = 1; i < 4; i++) begin
      bmem_wdata = b[i];
      tick();
      if (i < 3) begin
        chk({tag, " wr resp low"}, 64'(bmem_resp), 64'd0);
      end else begin
        chk({tag, " wr resp pulse"}, 64'(bmem_resp), 64'd1);
        chk({tag, " wr rdata zero"}, bmem_rdata, 64'd0);
      end
    end
    tick();
    chk({tag, " wr resp end"}, 64'(bmem_resp), 64'd0);
  endtask

  // Read with latency/beat checks; poke >= 0 pulses bmem_read during that beat.
  task automatic do_read(input logic [31:0] addr, input logic [63:0] e0, input logic [63:0] e1,
                         input logic [63:0] e2, input logic [63:0] e3, input string tag,
                         input int poke);
    logic [63:0] e[4];
    e = '{e0, e1, e2, e3};
    bmem_address = addr;
    bmem_read    = 1'b1;
    tick();
    bmem_read = 1'b0;
    chk({tag, " rd wait T"}, 64'(bmem_resp), 64'd0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk({tag, " rd wait"}, 64'(bmem_resp), 64'd0);
      chk({tag, " rd wait rdata"}, bmem_rdata, 64'd0);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      bmem_read = 1'b0;
      chk({tag, " rd beat resp"}, 64'(bmem_resp), 64'd1);
      chk({tag, " rd beat data"}, bmem_rdata, e[i]);
      if (i == poke) begin
        bmem_address = 32'h0000_0200;
        bmem_read    = 1'b1;
      end
    end
    tick();
    chk({tag, " rd end resp"}, 64'(bmem_resp), 64'd0);
    chk({tag, " rd end rdata"}, bmem_rdata, 64'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bmem_address = '0;
    bmem_read    = 1'b0;
    bmem_write   = 1'b0;
    bmem_wdata   = '0;
    #12;
    chk("reset resp", 64'(bmem_resp), 64'd0);
    chk("reset rdata", bmem_rdata, 64'd0);
    chk("reset error", 64'(bmem_error), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write then read back the same line.
    do_write(32'h0000_0100, 64'hA0A0_0000_0000_00A0, 64'hA1A1_0000_0000_00A1,
             64'hA2A2_0000_0000_00A2, 64'hA3A3_0000_0000_00A3, "w100");
    do_read(32'h0000_0100, 64'hA0A0_0000_0000_00A0, 64'hA1A1_0000_0000_00A1,
            64'hA2A2_0000_0000_00A2, 64'hA3A3_0000_0000_00A3, "r100", -1);

    // Write followed by a read in the very first idle cycle.
    do_write(32'h0000_0200, 64'hB0, 64'hB1, 64'hB2, 64'hB3, "w200");
    do_read(32'h0000_0200, 64'hB0, 64'hB1, 64'hB2, 64'hB3, "r200b2b", -1);
    chk("no error so far", 64'(bmem_error), 64'd0);

    // Read and write together: neither accepted.
    bmem_address = 32'h0000_0040;
    bmem_read    = 1'b1;
    bmem_write   = 1'b1;
    tick();
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    chk("rdwr resp", 64'(bmem_resp), 64'd0);
    tick();
    chk("rdwr resp later", 64'(bmem_resp), 64'd0);
    chk("rdwr error", 64'(bmem_error), 64'(ERR_EXP));
    do_read(32'h0000_0100, 64'hA0A0_0000_0000_00A0, 64'hA1A1_0000_0000_00A1,
            64'hA2A2_0000_0000_00A2, 64'hA3A3_0000_0000_00A3, "r100 after rdwr", -1);

    // Index wrap: bit 16 lies above the 8-bit index field.
    do_read(32'h0001_0100, 64'hA0A0_0000_0000_00A0, 64'hA1A1_0000_0000_00A1,
            64'hA2A2_0000_0000_00A2, 64'hA3A3_0000_0000_00A3, "r10100 wrap", -1);

    // Reset in the middle of a write leaves the old line intact.
    do_write(32'h0000_0080, 64'hC0, 64'hC1, 64'hC2, 64'hC3, "w80");
    bmem_address = 32'h0000_0080;
    bmem_write   = 1'b1;
    bmem_wdata   = 64'hD0;
    tick();
    bmem_write = 1'b0;
    bmem_wdata = 64'hD1;
    tick();
    bmem_wdata = 64'hD2;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst resp", 64'(bmem_resp), 64'd0);
    chk("midrst rdata", bmem_rdata, 64'd0);
    chk("midrst error", 64'(bmem_error), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_read(32'h0000_0080, 64'hC0, 64'hC1, 64'hC2, 64'hC3, "r80 old", -1);

    // Read pulse during a burst is ignored.
    do_read(32'h0000_0100, 64'hA0A0_0000_0000_00A0, 64'hA1A1_0000_0000_00A1,
            64'hA2A2_0000_0000_00A2, 64'hA3A3_0000_0000_00A3, "r100 poke", 1);
    chk("poke error", 64'(bmem_error), 64'(ERR_EXP));
    tick();
    chk("poke idle resp", 64'(bmem_resp), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
